// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the keypad scanner and the parameter-entry block:
// row drive patterns, key code constants, FSM state encoding and small
// decode helpers. No ports (package).
package keypad_pkg;

    // Scanner FSM state encoding.
    typedef enum logic [1:0] {
        ST_SCAN       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } kp_state_t;

    // Active-low row drive patterns, scanned in this order.
    localparam logic [3:0] ROW_0    = 4'b1110;
    localparam logic [3:0] ROW_1    = 4'b1101;
    localparam logic [3:0] ROW_2    = 4'b1011;
    localparam logic [3:0] ROW_3    = 4'b0111;

    // Idle column pattern (pull-ups, nothing pressed) and "no key" pattern.
    localparam logic [3:0] COL_IDLE = 4'b1111;

    // Key codes. Note the non-obvious mapping of D, * and #.
    localparam logic [3:0] KEY_0    = 4'h0;
    localparam logic [3:0] KEY_1    = 4'h1;
    localparam logic [3:0] KEY_2    = 4'h2;
    localparam logic [3:0] KEY_3    = 4'h3;
    localparam logic [3:0] KEY_4    = 4'h4;
    localparam logic [3:0] KEY_5    = 4'h5;
    localparam logic [3:0] KEY_6    = 4'h6;
    localparam logic [3:0] KEY_7    = 4'h7;
    localparam logic [3:0] KEY_8    = 4'h8;
    localparam logic [3:0] KEY_9    = 4'h9;
    localparam logic [3:0] KEY_A    = 4'hA;
    localparam logic [3:0] KEY_B    = 4'hB;
    localparam logic [3:0] KEY_C    = 4'hC;
    localparam logic [3:0] KEY_D    = 4'hF;
    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hD;
    localparam logic [3:0] KEY_NONE = 4'h0;

    // True when exactly one bit of an active-low pattern is low.
    function automatic logic single_low(input logic [3:0] pat);
        logic res;
        case (pat)
            4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

    // Next row in the scan sequence; 0111 wraps back to 1110.
    function automatic logic [3:0] row_rotate(input logic [3:0] row);
        return {row[2:0], row[3]};
    endfunction

    // Standard 4x4 layout:
    //   row0: 1 2 3 A   row1: 4 5 6 B   row2: 7 8 9 C   row3: * 0 # D
    // Column 0 is col bit 0.
    function automatic logic [3:0] key_code_of(input logic [3:0] row,
                                               input logic [3:0] col);
        logic [3:0] code;
        case ({row, col})
            {ROW_0, 4'b1110}: code = KEY_1;
            {ROW_0, 4'b1101}: code = KEY_2;
            {ROW_0, 4'b1011}: code = KEY_3;
            {ROW_0, 4'b0111}: code = KEY_A;
            {ROW_1, 4'b1110}: code = KEY_4;
            {ROW_1, 4'b1101}: code = KEY_5;
            {ROW_1, 4'b1011}: code = KEY_6;
            {ROW_1, 4'b0111}: code = KEY_B;
            {ROW_2, 4'b1110}: code = KEY_7;
            {ROW_2, 4'b1101}: code = KEY_8;
            {ROW_2, 4'b1011}: code = KEY_9;
            {ROW_2, 4'b0111}: code = KEY_C;
            {ROW_3, 4'b1110}: code = KEY_STAR;
            {ROW_3, 4'b1101}: code = KEY_0;
            {ROW_3, 4'b1011}: code = KEY_HASH;
            {ROW_3, 4'b0111}: code = KEY_D;
            default:          code = KEY_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_scan_sync2.sv
// sync2
// Two-flop synchronizer for the 4 asynchronous keypad column lines. Both
// stages reset to the idle (all-high) column pattern so a reset never looks
// like a key press.
// Ports:
//   clk   - system clock
//   reset - asynchronous active-high reset
//   d     - raw asynchronous columns
//   q     - synchronized columns
module sync2
    import keypad_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] d,
    output logic [3:0] q
);

    logic [3:0] meta_r;
    logic [3:0] sync_r;

    // Two-stage capture of the column lines.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= COL_IDLE;
            sync_r <= COL_IDLE;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/keypad_scan.sv
// keypad_scan
// 4x4 matrix keypad scanner with press and release debouncing. Rows are
// driven low one at a time; the synchronized columns are sampled on the last
// dwell cycle of each row. A single-key hit freezes the scan and is debounced
// before being reported; the key is then held until a debounced release.
// Ports:
//   clk         - system clock, all state on the rising edge
//   reset       - asynchronous active-high reset
//   col_in      - raw active-low columns (asynchronous)
//   row_out     - active-low row drive, at most one bit low
//   key_row     - row pattern of the accepted key, 1111 when none
//   key_col     - column pattern of the accepted key, 1111 when none
//   key_code    - hex code of the accepted key, 0 when none
//   key_valid   - one-cycle pulse when a press is accepted
//   key_pressed - high from key_valid until the release is debounced
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int DEBOUNCE_CNT = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_in,
    output logic [3:0] row_out,
    output logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int DIV_W = $clog2(SCAN_DIV) + 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CNT) + 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CNT - 1);
    localparam logic [DB_W-1:0]  DB_ONE   = DB_W'(1);

    logic [3:0]       col_s;

    kp_state_t        state_r;
    kp_state_t        state_next_s;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_next_s;
    logic [DB_W-1:0]  db_r;
    logic [DB_W-1:0]  db_next_s;
    logic [3:0]       row_r;
    logic [3:0]       row_next_s;
    logic [3:0]       cap_col_r;
    logic [3:0]       cap_col_next_s;

    logic             accept_s;
    logic             release_done_s;

    logic [3:0]       key_row_r;
    logic [3:0]       key_col_r;
    logic [3:0]       key_code_r;
    logic             key_valid_r;
    logic             key_pressed_r;
    logic [3:0]       key_row_next_s;
    logic [3:0]       key_col_next_s;
    logic [3:0]       key_code_next_s;
    logic             key_valid_next_s;
    logic             key_pressed_next_s;

    sync2 u_sync2 (
        .clk   (clk),
        .reset (reset),
        .d     (col_in),
        .q     (col_s)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_SCAN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and counter/capture logic. The row pattern itself is the
    // captured row: it stays frozen from capture until the scan restarts.
    always_comb begin
        state_next_s   = state_r;
        div_next_s     = div_r;
        db_next_s      = db_r;
        row_next_s     = row_r;
        cap_col_next_s = cap_col_r;
        accept_s       = 1'b0;
        release_done_s = 1'b0;
        case (state_r)
            ST_SCAN: begin
                if (div_r >= DIV_LAST) begin
                    div_next_s = '0;
                    if (single_low(col_s)) begin
                        state_next_s   = ST_PRESS_DB;
                        cap_col_next_s = col_s;
                        db_next_s      = '0;
                    end else begin
                        // Idle or ghosting/multi-press: keep scanning.
                        row_next_s = row_rotate(row_r);
                    end
                end else begin
                    div_next_s = div_r + DIV_ONE;
                end
            end
            ST_PRESS_DB: begin
                if (col_s == cap_col_r) begin
                    // Counter never passes its terminal value: the last
                    // matching cycle leaves the state instead of counting.
                    if (db_r >= DB_LAST) begin
                        accept_s     = 1'b1;
                        state_next_s = ST_HELD;
                        db_next_s    = '0;
                    end else begin
                        db_next_s = db_r + DB_ONE;
                    end
                end else begin
                    state_next_s = ST_SCAN;
                    row_next_s   = ROW_0;
                    div_next_s   = '0;
                    db_next_s    = '0;
                end
            end
            ST_HELD: begin
                if (col_s == COL_IDLE) begin
                    state_next_s = ST_RELEASE_DB;
                    db_next_s    = '0;
                end else begin
                    // Any low column (including a second key) keeps us held.
                    state_next_s = ST_HELD;
                end
            end
            ST_RELEASE_DB: begin
                if (col_s == COL_IDLE) begin
                    if (db_r >= DB_LAST) begin
                        release_done_s = 1'b1;
                        state_next_s   = ST_SCAN;
                        row_next_s     = ROW_0;
                        div_next_s     = '0;
                        db_next_s      = '0;
                    end else begin
                        db_next_s = db_r + DB_ONE;
                    end
                end else begin
                    state_next_s = ST_HELD;
                    db_next_s    = '0;
                end
            end
            default: begin
                state_next_s = ST_SCAN;
                row_next_s   = ROW_0;
                div_next_s   = '0;
                db_next_s    = '0;
            end
        endcase
    end

    // Next values of the reported key outputs.
    always_comb begin
        key_valid_next_s   = 1'b0;
        key_row_next_s     = key_row_r;
        key_col_next_s     = key_col_r;
        key_code_next_s    = key_code_r;
        key_pressed_next_s = key_pressed_r;
        if (accept_s) begin
            key_valid_next_s   = 1'b1;
            key_row_next_s     = row_r;
            key_col_next_s     = cap_col_r;
            key_code_next_s    = key_code_of(row_r, cap_col_r);
            key_pressed_next_s = 1'b1;
        end else if (release_done_s) begin
            key_row_next_s     = COL_IDLE;
            key_col_next_s     = COL_IDLE;
            key_code_next_s    = KEY_NONE;
            key_pressed_next_s = 1'b0;
        end else begin
            key_pressed_next_s = key_pressed_r;
        end
    end

    // Scan/debounce datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_r     <= '0;
            db_r      <= '0;
            row_r     <= ROW_0;
            cap_col_r <= COL_IDLE;
        end else begin
            div_r     <= div_next_s;
            db_r      <= db_next_s;
            row_r     <= row_next_s;
            cap_col_r <= cap_col_next_s;
        end
    end

    // Registered key outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_row_r     <= COL_IDLE;
            key_col_r     <= COL_IDLE;
            key_code_r    <= KEY_NONE;
            key_valid_r   <= 1'b0;
            key_pressed_r <= 1'b0;
        end else begin
            key_row_r     <= key_row_next_s;
            key_col_r     <= key_col_next_s;
            key_code_r    <= key_code_next_s;
            key_valid_r   <= key_valid_next_s;
            key_pressed_r <= key_pressed_next_s;
        end
    end

    assign row_out     = row_r;
    assign key_row     = key_row_r;
    assign key_col     = key_col_r;
    assign key_code    = key_code_r;
    assign key_valid   = key_valid_r;
    assign key_pressed = key_pressed_r;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
// Scoreboard bench for keypad_scan with SCAN_DIV=4, DEBOUNCE_CNT=8. A small
// keypad model turns the frozen/rotating row drive plus the pressed key into
// col_in. Stimulus pushes expected key events into a queue; a monitor pops and
// compares whenever key_valid is seen and flags any unexpected key_valid.
module tb_keypad_scan;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CNT = 8;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] col_in = 4'b1111;
    logic [3:0] row_out;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;

    keypad_scan #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .col_in      (col_in),
        .row_out     (row_out),
        .key_row     (key_row),
        .key_col     (key_col),
        .key_code    (key_code),
        .key_valid   (key_valid),
        .key_pressed (key_pressed)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] code;
        logic [3:0] row;
        logic [3:0] col;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Keypad model state.
    bit         press_on  = 1'b0;
    bit         ghost_on  = 1'b0;
    logic [1:0] press_row = 2'd0;
    logic [1:0] press_col = 2'd0;

    function automatic logic [3:0] pad_model();
        logic [3:0] c;
        c = 4'b1111;
        if (press_on && (row_out[press_row] == 1'b0)) c[press_col] = 1'b0;
        if (ghost_on && (row_out == 4'b1110)) c = 4'b1100;
        return c;
    endfunction

    // Physical keypad: columns follow the row drive, updated on falling edges.
    initial begin
        forever begin
            @(negedge clk);
            col_in = pad_model();
        end
    end

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [3:0] code, input logic [3:0] row, input logic [3:0] col);
        exp_t e;
        e.code = code;
        e.row  = row;
        e.col  = col;
        exp_q.push_back(e);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_drain(input string name, input int bound);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < bound) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d key events pending after %0d cycles, required 0", name, exp_q.size(), bound);
            exp_q.delete();
        end
    endtask

    task automatic wait_release(input string name, input int bound);
        int i;
        i = 0;
        while (key_pressed && i < bound) begin
            @(negedge clk);
            i++;
        end
        check4({name, "_pressed"}, {3'b000, key_pressed}, 4'h0);
        check4({name, "_key_row"}, key_row, 4'b1111);
        check4({name, "_key_col"}, key_col, 4'b1111);
        check4({name, "_key_code"}, key_code, 4'h0);
    endtask

    // Monitor: every key_valid must match the next expected event.
    initial begin
        exp_t e;
        bit   prev_valid;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
            end else begin
                if (key_valid) begin
                    check4("valid_not_back_to_back", {3'b000, prev_valid}, 4'h0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_valid: key_valid=1 code=%h, required no key_valid", key_code);
                    end else begin
                        e = exp_q.pop_front();
                        check4("sb_key_code", key_code, e.code);
                        check4("sb_key_row", key_row, e.row);
                        check4("sb_key_col", key_col, e.col);
                        check4("sb_key_pressed", {3'b000, key_pressed}, 4'h1);
                    end
                end
                prev_valid = key_valid;
            end
        end
    end

    // Overall time limit.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rows [4];
        bit         saw_row3;
        rows[0] = 4'b1110;
        rows[1] = 4'b1101;
        rows[2] = 4'b1011;
        rows[3] = 4'b0111;

        // Reset values and row rotation with wrap.
        reset = 1'b1;
        cycles(3);
        reset = 1'b0;
        #1;
        check4("rst_row_out", row_out, 4'b1110);
        check4("rst_key_row", key_row, 4'b1111);
        check4("rst_key_col", key_col, 4'b1111);
        check4("rst_key_code", key_code, 4'h0);
        check4("rst_key_valid", {3'b000, key_valid}, 4'h0);
        check4("rst_key_pressed", {3'b000, key_pressed}, 4'h0);
        @(negedge clk);
        for (int k = 1; k <= 16; k++) begin
            check4($sformatf("rotate_k%0d", k), row_out, rows[(k / 4) % 4]);
            @(negedge clk);
        end

        // Press '5' for 30 cycles, then release.
        push_exp(4'h5, 4'b1101, 4'b1101);
        press_row = 2'd1;
        press_col = 2'd1;
        press_on  = 1'b1;
        cycles(30);
        wait_drain("press_5", 20);
        check4("press_5_held", {3'b000, key_pressed}, 4'h1);
        press_on = 1'b0;
        cycles(6);
        check4("press_5_release_pending", {3'b000, key_pressed}, 4'h1);
        wait_release("release_5", 20);

        // Ghosting on row 1110: no key, scanning continues.
        ghost_on = 1'b1;
        saw_row3 = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (row_out == 4'b0111) saw_row3 = 1'b1;
        end
        ghost_on = 1'b0;
        check4("ghost_scan_continues", {3'b000, saw_row3}, 4'h1);
        check4("ghost_no_press", {3'b000, key_pressed}, 4'h0);

        // Bouncing '1', then stable.
        press_row = 2'd0;
        press_col = 2'd0;
        for (int i = 0; i < 20; i++) begin
            press_on = (((i / 3) % 2) == 0);
            @(negedge clk);
        end
        check4("bounce_no_press", {3'b000, key_pressed}, 4'h0);
        press_on = 1'b1;
        push_exp(4'h1, 4'b1110, 4'b1110);
        wait_drain("bounce_1", 40);
        press_on = 1'b0;
        wait_release("release_1", 30);

        // 'D' held, release with two one-cycle glitch lows.
        press_row = 2'd3;
        press_col = 2'd3;
        push_exp(4'hF, 4'b0111, 4'b0111);
        press_on = 1'b1;
        cycles(30);
        wait_drain("press_d", 20);
        press_on = 1'b0;
        cycles(3);
        press_on = 1'b1;
        cycles(1);
        press_on = 1'b0;
        cycles(3);
        check4("d_glitch1_held", {3'b000, key_pressed}, 4'h1);
        press_on = 1'b1;
        cycles(1);
        press_on = 1'b0;
        cycles(6);
        check4("d_glitch2_held", {3'b000, key_pressed}, 4'h1);
        check4("d_code_held", key_code, 4'hF);
        wait_release("release_d", 30);
        cycles(5);

        // Reset in the middle of press debounce.
        press_row = 2'd0;
        press_col = 2'd0;
        press_on  = 1'b1;
        reset = 1'b1;
        cycles(2);
        reset = 1'b0;
        cycles(7);
        check4("mid_db_row_frozen", row_out, 4'b1110);
        check4("mid_db_no_valid", {3'b000, key_pressed}, 4'h0);
        reset = 1'b1;
        #1;
        check4("mid_rst_row_out", row_out, 4'b1110);
        check4("mid_rst_key_row", key_row, 4'b1111);
        check4("mid_rst_key_col", key_col, 4'b1111);
        check4("mid_rst_key_code", key_code, 4'h0);
        check4("mid_rst_key_valid", {3'b000, key_valid}, 4'h0);
        check4("mid_rst_key_pressed", {3'b000, key_pressed}, 4'h0);
        press_on = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        cycles(40);
        check4("mid_rst_after_pressed", {3'b000, key_pressed}, 4'h0);
        check4("mid_rst_after_code", key_code, 4'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
